// File: rtl/multi_digit_seg_driver.sv
// multi_digit_seg_driver
//
// Converts a binary value to BCD with a sequential double-dabble engine and
// drives a multiplexed common-anode 7-segment display with per-digit decimal
// points, optional leading-zero blanking, an overflow indication and a
// 16-level PWM brightness gate.
//
// Ports
//   CLK         in   clock, all state updates on the rising edge
//   RESET       in   synchronous active-low reset
//   BIN_IN      in   [BIN_WIDTH-1:0] unsigned value to convert
//   LOAD        in   single-cycle convert request
//   DOTS_IN     in   [DIGITS-1:0] decimal-point request per digit, 1 = lit
//   BLANK_EN    in   1 = blank leading zeros
//   BRIGHTNESS  in   [3:0] duty level, 15 = full on, 0 = 1/16
//   SEG_SELECT  out  [DIGITS-1:0] active-low one-hot digit enable
//   DEC_OUT     out  [7:0] active-low segments {dp,g,f,e,d,c,b,a}
//   BUSY        out  conversion in progress
//   OVERFLOW    out  displayed value does not fit in DIGITS decimal digits
//   FSM_STATE   out  [1:0] converter state (0 idle, 1 shift, 2 commit)
//
// LOAD/BUSY handshake: LOAD is a request and BUSY is the inverse of ready.
// A cycle with LOAD=1 and BUSY=0 is a transfer and captures BIN_IN; LOAD=1
// while BUSY=1 is dropped (not queued) and does not disturb the conversion.
module multi_digit_seg_driver #(
    parameter int DIGITS      = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [BIN_WIDTH-1:0] BIN_IN,
    input  logic                 LOAD,
    input  logic [DIGITS-1:0]    DOTS_IN,
    input  logic                 BLANK_EN,
    input  logic [3:0]           BRIGHTNESS,
    output logic [DIGITS-1:0]    SEG_SELECT,
    output logic [7:0]           DEC_OUT,
    output logic                 BUSY,
    output logic                 OVERFLOW,
    output logic [1:0]           FSM_STATE
);

    // One extra nibble above the displayable digits catches overflow.
    localparam int BCD_W = 4 * DIGITS + 4;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(BIN_WIDTH);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // Converter state
    // ---------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [BIN_WIDTH-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [BCD_W-1:0]        bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_seen_q, ovf_seen_d;
    logic [4*DIGITS-1:0]     disp_q, disp_d;
    logic                    ovf_q, ovf_d;

    // Double-dabble adjust: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < DIGITS + 1; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_seen_d = ovf_seen_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (LOAD) begin
                    bin_d      = BIN_IN;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_seen_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The overflow nibble can itself wrap for wide inputs, so
                // remember that it was ever non-zero rather than trusting
                // only its final contents.
                ovf_seen_d = ovf_seen_q | (|bcd_q[BCD_W-1 -: 4]);
                bcd_d      = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
                bin_d      = {bin_q[BIN_WIDTH-2:0], 1'b0};
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d  = bcd_q[4*DIGITS-1:0];
                ovf_d   = ovf_seen_q | (|bcd_q[BCD_W-1 -: 4]);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_seen_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_seen_q <= ovf_seen_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign OVERFLOW  = ovf_q;
    assign FSM_STATE = state_q;

    // ---------------------------------------------------------------
    // Scan / PWM / segment output
    // ---------------------------------------------------------------
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        pwm_q, pwm_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        dec_q, dec_d;
    logic              tick;
    logic              gate;
    logic [DIGITS-1:0] blank_vec;
    logic              zero_above;
    logic [3:0]        cur_nib;
    logic              cur_dot;
    logic              cur_blank;
    logic [6:0]        seg;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    always_comb begin
        tick  = (pre_q == PRE_W'(REFRESH_DIV - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        pwm_d = pwm_q + 4'd1;
        gate  = (pwm_q <= BRIGHTNESS);
    end

    // A digit is blankable when it and every digit above it are zero.
    // Digit 0 is never part of the blankable run.
    always_comb begin
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (disp_q[4*i +: 4] == 4'd0);
            blank_vec[i] = zero_above;
        end
    end

    always_comb begin
        cur_nib   = disp_q[3:0];
        cur_dot   = DOTS_IN[0];
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_dot   = DOTS_IN[i];
                cur_blank = blank_vec[i];
            end
        end
        if (ovf_q) begin
            seg = 7'h3F;                // '-' : only segment g lit
        end else if (BLANK_EN && cur_blank) begin
            seg = 7'h7F;
        end else begin
            seg = seg_code(cur_nib);
        end
        dec_d = {~cur_dot, seg};
        sel_d = gate ? ~(DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pre_q <= '0;
            idx_q <= '0;
            pwm_q <= 4'd0;
            sel_q <= '1;
            dec_q <= 8'hFF;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            pwm_q <= pwm_d;
            sel_q <= sel_d;
            dec_q <= dec_d;
        end
    end

    assign SEG_SELECT = sel_q;
    assign DEC_OUT    = dec_q;

endmodule

// File: tb/tb_multi_digit_seg_driver.sv
// tb_multi_digit_seg_driver
//
// Directed bench for multi_digit_seg_driver with DIGITS=4, BIN_WIDTH=14,
// REFRESH_DIV=16. Inputs change on the falling edge, outputs are sampled on
// the falling edge. Expected digit patterns are hand-computed constants
// queued in exp_q and consumed by each scenario.
module tb_multi_digit_seg_driver;

    localparam int DIGITS      = 4;
    localparam int BIN_WIDTH   = 14;
    localparam int REFRESH_DIV = 16;

    // ---------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 load;
    logic [DIGITS-1:0]    dots_in;
    logic                 blank_en;
    logic [3:0]           brightness;
    logic [DIGITS-1:0]    seg_select;
    logic [7:0]           dec_out;
    logic                 busy;
    logic                 overflow;
    logic [1:0]           fsm_state;

    always #5 clk = ~clk;

    multi_digit_seg_driver #(
        .DIGITS      (DIGITS),
        .BIN_WIDTH   (BIN_WIDTH),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .BIN_IN     (bin_in),
        .LOAD       (load),
        .DOTS_IN    (dots_in),
        .BLANK_EN   (blank_en),
        .BRIGHTNESS (brightness),
        .SEG_SELECT (seg_select),
        .DEC_OUT    (dec_out),
        .BUSY       (busy),
        .OVERFLOW   (overflow),
        .FSM_STATE  (fsm_state)
    );

    // ---------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    // ---------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------
    // Issue a one-cycle LOAD; returns on the falling edge after the
    // accepting rising edge.
    task automatic pulse_load(input logic [BIN_WIDTH-1:0] v);
        @(negedge clk);
        bin_in = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Count falling edges on which BUSY is still high (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Wait (bounded) until digit idx is enabled and return its segments.
    task automatic scan_digit(input int idx, output logic [7:0] dec, output bit found);
        logic [DIGITS-1:0] want;
        want  = ~(DIGITS'(1) << idx);
        found = 1'b0;
        dec   = 8'hxx;
        @(negedge clk);
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (seg_select === want) begin
                found = 1'b1;
                dec   = dec_out;
            end
        end
    endtask

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (seg_select !== 4'hF) begin
            bad++; $display("FAIL reset_seg_select: got %h want %h", seg_select, 4'hF);
        end
        total++;
        if (dec_out !== 8'hFF) begin
            bad++; $display("FAIL reset_dec_out: got %h want %h", dec_out, 8'hFF);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end
        total++;
        if (fsm_state !== 2'd0) begin
            bad++; $display("FAIL reset_fsm_state: got %0d want 0", fsm_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_convert();
        int n;
        logic [7:0] d;
        bit f;
        logic [7:0] e;
        pulse_load(14'd1234);
        wait_idle(n);
        total++;
        if (n !== 15) begin
            bad++; $display("FAIL convert_busy_cycles: got %0d want 15", n);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL convert_overflow: got %b want 0", overflow);
        end
        exp_q = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        for (int i = 0; i < DIGITS; i++) begin
            e = exp_q.pop_front();
            scan_digit(i, d, f);
            total++;
            if (!f || d !== e) begin
                bad++; $display("FAIL convert_digit%0d: got %h (found=%0d) want %h", i, d, f, e);
            end
        end
    endtask

    task automatic test_overflow_busy();
        int n;
        logic [7:0] d;
        bit f;
        logic [7:0] e;
        pulse_load(14'd12000);
        repeat (3) @(negedge clk);
        bin_in = 14'd5;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL ovf_busy_during: got %b want 1", busy);
        end
        wait_idle(n);
        total++;
        if (n !== 11) begin
            bad++; $display("FAIL ovf_busy_remaining: got %0d want 11", n);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL ovf_ignored_load_restart: got %b want 0", busy);
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_set: got %b want 1", overflow);
        end
        exp_q = '{8'hBF, 8'hBF, 8'hBF, 8'hBF};
        for (int i = 0; i < DIGITS; i++) begin
            e = exp_q.pop_front();
            scan_digit(i, d, f);
            total++;
            if (!f || d !== e) begin
                bad++; $display("FAIL ovf_digit%0d: got %h (found=%0d) want %h", i, d, f, e);
            end
        end
        pulse_load(14'd9999);
        wait_idle(n);
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_cleared: got %b want 0", overflow);
        end
        exp_q = '{8'h90, 8'h90, 8'h90, 8'h90};
        for (int i = 0; i < DIGITS; i++) begin
            e = exp_q.pop_front();
            scan_digit(i, d, f);
            total++;
            if (!f || d !== e) begin
                bad++; $display("FAIL max_digit%0d: got %h (found=%0d) want %h", i, d, f, e);
            end
        end
    endtask

    task automatic test_blanking();
        int n;
        logic [7:0] d;
        bit f;
        logic [7:0] e;
        blank_en = 1'b1;
        pulse_load(14'd7);
        wait_idle(n);
        exp_q = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < DIGITS; i++) begin
            e = exp_q.pop_front();
            scan_digit(i, d, f);
            total++;
            if (!f || d !== e) begin
                bad++; $display("FAIL blank_on_digit%0d: got %h (found=%0d) want %h", i, d, f, e);
            end
        end
        blank_en = 1'b0;
        exp_q = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
        for (int i = 0; i < DIGITS; i++) begin
            e = exp_q.pop_front();
            scan_digit(i, d, f);
            total++;
            if (!f || d !== e) begin
                bad++; $display("FAIL blank_off_digit%0d: got %h (found=%0d) want %h", i, d, f, e);
            end
        end
        dots_in  = 4'b0100;
        blank_en = 1'b1;
        scan_digit(2, d, f);
        total++;
        if (!f || d !== 8'h7F) begin
            bad++; $display("FAIL dot_blanked_digit2: got %h (found=%0d) want 7f", d, f);
        end
        blank_en = 1'b0;
        scan_digit(2, d, f);
        total++;
        if (!f || d !== 8'h40) begin
            bad++; $display("FAIL dot_zero_digit2: got %h (found=%0d) want 40", d, f);
        end
        scan_digit(0, d, f);
        total++;
        if (!f || d !== 8'hF8) begin
            bad++; $display("FAIL dot_other_digit0: got %h (found=%0d) want f8", d, f);
        end
        dots_in = 4'b0000;
    endtask

    task automatic test_brightness();
        int active;
        int onehot_bad;
        logic [3:0] levels [3];
        int         want   [3];
        levels = '{4'd0, 4'd7, 4'd15};
        want   = '{4, 32, 64};
        for (int l = 0; l < 3; l++) begin
            brightness = levels[l];
            repeat (2) @(negedge clk);
            active     = 0;
            onehot_bad = 0;
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                if (seg_select !== 4'hF) begin
                    active++;
                    if ($countones(~seg_select) != 1) onehot_bad++;
                end
            end
            total++;
            if (active !== want[l] || onehot_bad !== 0) begin
                bad++;
                $display("FAIL brightness_%0d: got %0d active (%0d not one-hot) want %0d active",
                         levels[l], active, onehot_bad, want[l]);
            end
        end
        brightness = 4'd15;
    endtask

    task automatic test_reset_abort();
        int n;
        logic [7:0] d;
        bit f;
        logic [7:0] e;
        blank_en = 1'b1;
        pulse_load(14'd4321);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || overflow !== 1'b0 || fsm_state !== 2'd0) begin
            bad++; $display("FAIL abort_state: got busy=%b ovf=%b state=%0d want 0 0 0",
                            busy, overflow, fsm_state);
        end
        total++;
        if (seg_select !== 4'hF || dec_out !== 8'hFF) begin
            bad++; $display("FAIL abort_outputs: got sel=%h dec=%h want f ff", seg_select, dec_out);
        end
        rst_n = 1'b1;
        // Display cleared to zero; digit 0 shows 0 even with blanking on.
        exp_q = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < DIGITS; i++) begin
            e = exp_q.pop_front();
            scan_digit(i, d, f);
            total++;
            if (!f || d !== e) begin
                bad++; $display("FAIL abort_zero_digit%0d: got %h (found=%0d) want %h", i, d, f, e);
            end
        end
        // Reset again and issue LOAD on the very first cycle out of reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        bin_in = 14'd4321;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        wait_idle(n);
        total++;
        if (n !== 15) begin
            bad++; $display("FAIL abort_reload_busy: got %0d want 15", n);
        end
        exp_q = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        for (int i = 0; i < DIGITS; i++) begin
            e = exp_q.pop_front();
            scan_digit(i, d, f);
            total++;
            if (!f || d !== e) begin
                bad++; $display("FAIL abort_reload_digit%0d: got %h (found=%0d) want %h", i, d, f, e);
            end
        end
    endtask

    // ---------------------------------------------------------------
    // Sequence and final report
    // ---------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        bin_in     = '0;
        load       = 1'b0;
        dots_in    = '0;
        blank_en   = 1'b0;
        brightness = 4'd15;
        test_reset();
        test_convert();
        test_overflow_busy();
        test_blanking();
        test_brightness();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/multi_digit_seg_driver.md
MULTI_DIGIT_SEG_DRIVER -- requirements
Module: multi_digit_seg_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits; legal range 1..8.
REQ-002 Parameter BIN_WIDTH, default 14: width of the binary input value; legal range 4..27.
REQ-003 Parameter REFRESH_DIV, default 50000: clocks per digit slot (1 kHz at 50 MHz); legal minimum 16.
REQ-004 CLK  input  1: single clock; all state is updated on its rising edge.
REQ-005 RESET  input  1: synchronous, active-low reset (0 = reset), sampled on the CLK rising edge.
REQ-006 BIN_IN  input  BIN_WIDTH: unsigned binary value to display.
REQ-007 LOAD  input  1: single-cycle request to convert and display BIN_IN.
REQ-008 DOTS_IN  input  DIGITS: per-digit decimal-point request, 1 = lit, sampled live.
REQ-009 BLANK_EN  input  1: 1 = leading-zero blanking enabled.
REQ-010 BRIGHTNESS  input  4: duty level; 15 = full on, 0 = 1/16 duty.
REQ-011 SEG_SELECT  output  DIGITS: active-low one-hot digit enable; bit i drives digit i, where digit 0 is least significant.
REQ-012 DEC_OUT  output  8: active-low segment pattern; bit7 = DP, bits6..0 = g,f,e,d,c,b,a.
REQ-013 BUSY  output  1: high while a conversion is in progress.
REQ-014 OVERFLOW  output  1: high while the displayed value exceeds 10^DIGITS-1.

Function
REQ-015 The block SHALL start a conversion on a cycle where LOAD=1 and BUSY=0, capturing BIN_IN into an internal shift register.
REQ-016 The block SHALL ignore LOAD=1 while BUSY=1; the captured value is not changed.
REQ-017 The conversion SHALL use sequential double-dabble (add 3 to each nibble >= 5, then shift one bit per clock), using a 4*DIGITS-bit BCD register plus one overflow-detect nibble.
REQ-018 The FSM SHALL have three states: IDLE -> SHIFT on an accepted LOAD; SHIFT for exactly BIN_WIDTH clocks; SHIFT -> COMMIT; COMMIT -> IDLE after one clock.
REQ-019 BUSY SHALL be 1 in SHIFT and COMMIT, giving BIN_WIDTH+1 cycles of BUSY per conversion; the display register SHALL update atomically at COMMIT and never show partial results.
REQ-020 OVERFLOW SHALL be set at COMMIT when the overflow nibble is non-zero; while OVERFLOW=1, every digit SHALL show '-' (DEC_OUT=8'hBF, with DP per DOTS_IN).
REQ-021 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; a tick on its terminal count SHALL advance the digit index 0..DIGITS-1, wrapping to 0.
REQ-022 SEG_SELECT SHALL drive low only the bit of the current digit index, and only while the PWM gate is open; otherwise it SHALL be all ones.
REQ-023 The PWM gate SHALL use a free-running 4-bit counter incremented every clock; the gate is open when counter <= BRIGHTNESS.
REQ-024 Segment codes (bits6..0) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); DEC_OUT bit7 SHALL be the inverse of DOTS_IN[index].
REQ-025 When BLANK_EN=1, every digit above the most significant non-zero digit SHALL show 7'h7F (blank); digit 0 SHALL never be blanked; DP SHALL still follow DOTS_IN.
REQ-026 SEG_SELECT and DEC_OUT SHALL be registered, with one cycle of latency from the index/prescaler state.
REQ-027 If a tick and a COMMIT fall in the same cycle, the new digit SHALL show the newly committed value.

Reset
REQ-028 While RESET=0, the block SHALL force: SEG_SELECT all ones; DEC_OUT=8'hFF; BUSY=0; OVERFLOW=0; display register=0; FSM=IDLE; prescaler, PWM counter and digit index=0.
REQ-029 A RESET asserted mid-conversion SHALL abort the conversion, leave no partial commit, and accept a new LOAD on the first cycle after RESET=1.

Verification (DIGITS=4, BIN_WIDTH=14, REFRESH_DIV=16 unless stated)
REQ-030 Reset: hold RESET=0 for 3 clocks -> SEG_SELECT=4'hF, DEC_OUT=8'hFF, BUSY=0, OVERFLOW=0.
REQ-031 Convert: LOAD with BIN_IN=1234, BRIGHTNESS=15, DOTS_IN=0 -> BUSY high for 15 cycles; digits 0..3 then show 99, B0, A4, F9 with SEG_SELECT E, D, B, 7 respectively.
REQ-032 Overflow and busy: LOAD with BIN_IN=12000 -> OVERFLOW=1 and all digits show BF; a LOAD of 5 during BUSY is ignored; a following LOAD of 9999 clears OVERFLOW.
REQ-033 Blanking: BIN_IN=7 with BLANK_EN=1 -> digit 0 shows F8 and digits 1..3 show FF; with BLANK_EN=0, digits 1..3 show C0; DOTS_IN=4'b0100 -> digit 2 shows 7F (blanked) or 40.
REQ-034 Brightness and reset abort: BRIGHTNESS=0 -> SEG_SELECT active for 1 clock in every 16; RESET=0 at SHIFT cycle 6 -> BUSY=0, display stays 0, and the next LOAD converts normally.
